// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Optional forwarding outputs are enabled with RF_WB_BYPASS_EN.
package rf_wb_pkg;

   localparam int unsigned XLEN_DEFAULT = 64;
   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned NUM_REGS     = 32;
   localparam int unsigned LAST_REG     = NUM_REGS - 1;

   typedef enum logic {INIT, RUN} rf_wb_state_t;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from rr_ptr with wrap-around and
// moves the pointer past the winner whenever a grant is issued.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W-1:0] rr_ptr_q;

   always_comb begin
      logic [IDX_W-1:0] idx;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = '0;
      if (enable) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = IDX_W'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
               grant[idx]  = 1'b1;
               grant_idx   = idx;
               grant_valid = 1'b1;
            end
         end
      end
   end

   // A grant is always a transfer, since ready is the grant itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
      end else if (grant_valid) begin
         rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: zero-fills x1..x31 after reset, then shares the
// port round-robin among requesters. RF_WB_BYPASS_EN adds forwarding outputs.
module regfile_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned XLEN    = XLEN_DEFAULT
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_reg,
   input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic                                 rf_write_enable,
   output reg_addr_t                            rf_write_register,
   output logic [XLEN-1:0]                      rf_write_value,
   input  logic                                 rf_write_ready,
   output logic                                 init_done
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                                 byp_valid,
   output reg_addr_t                            byp_reg,
   output logic [XLEN-1:0]                      byp_data
`endif
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   rf_wb_state_t     state_q;
   reg_addr_t        cnt_q;
   logic             stg_valid_q;
   reg_addr_t        stg_reg_q;
   logic [XLEN-1:0]  stg_data_q;
   logic             stage_free;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;

   assign stage_free = !stg_valid_q || rf_write_ready;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk         (clk),
      .reset       (reset),
      .req         (req_valid),
      .enable      ((state_q == RUN) && stage_free),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= INIT;
         cnt_q       <= reg_addr_t'(1);
         stg_valid_q <= 1'b0;
         stg_reg_q   <= '0;
         stg_data_q  <= '0;
      end else if (stage_free) begin
         unique case (state_q)
            INIT: begin
               stg_valid_q <= 1'b1;
               stg_reg_q   <= cnt_q;
               stg_data_q  <= '0;
               cnt_q       <= cnt_q + reg_addr_t'(1);
               if (cnt_q == reg_addr_t'(LAST_REG)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (grant_valid) begin
                  // x0 writes complete the handshake but never reach the port.
                  stg_valid_q <= (req_reg[grant_idx] != '0);
                  stg_reg_q   <= req_reg[grant_idx];
                  stg_data_q  <= req_data[grant_idx];
               end else begin
                  stg_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign req_ready         = grant;
   assign rf_write_enable   = stg_valid_q;
   assign rf_write_register = stg_reg_q;
   assign rf_write_value    = stg_data_q;
   assign init_done         = (state_q == RUN);

`ifdef RF_WB_BYPASS_EN
   assign byp_valid = stg_valid_q && (state_q == RUN);
   assign byp_reg   = stg_reg_q;
   assign byp_data  = stg_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a queue-based model of the
// expected write stream. Define RF_WB_BYPASS_EN to also check the forwarding outputs.
module tb_regfile_wb_arbiter;

   localparam int NR = 3;

   typedef struct {
      logic [4:0]  r;
      logic [63:0] d;
   } wr_t;

   logic                  clk;
   logic                  reset;
   logic [NR-1:0]         req_valid;
   logic [NR-1:0][4:0]    req_reg;
   logic [NR-1:0][63:0]   req_data;
   logic [NR-1:0]         req_ready;
   logic                  rf_write_enable;
   logic [4:0]            rf_write_register;
   logic [63:0]           rf_write_value;
   logic                  rf_write_ready;
   logic                  init_done;
`ifdef RF_WB_BYPASS_EN
   logic                  byp_valid;
   logic [4:0]            byp_reg;
   logic [63:0]           byp_data;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model: write stream still owed to the register file, zero-fill progress and
   // the round-robin start position.
   wr_t q[$];
   int  fill_next;
   int  rr;

   regfile_wb_arbiter #(
      .NUM_REQ (NR),
      .XLEN    (64)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_reg           (req_reg),
      .req_data          (req_data),
      .req_ready         (req_ready),
      .rf_write_enable   (rf_write_enable),
      .rf_write_register (rf_write_register),
      .rf_write_value    (rf_write_value),
      .rf_write_ready    (rf_write_ready),
      .init_done         (init_done)
`ifdef RF_WB_BYPASS_EN
      ,
      .byp_valid         (byp_valid),
      .byp_reg           (byp_reg),
      .byp_data          (byp_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs();
      check("rst_wr_en", rf_write_enable, 1'b0);
      check("rst_wr_reg", rf_write_register, 5'd0);
      check("rst_wr_val", rf_write_value, 64'd0);
      check("rst_ready", req_ready, 3'b000);
      check("rst_init_done", init_done, 1'b0);
`ifdef RF_WB_BYPASS_EN
      check("rst_byp_valid", byp_valid, 1'b0);
`endif
   endtask

   // Called at a negedge; releases reset at a negedge.
   task automatic do_reset();
      req_valid = '1;
      reset     = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      fill_next = 1;
      rr        = 0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_reset_outputs();
      reset = 1'b1;
   endtask

   // Inputs are already driven (at a negedge); check, advance model, cross one edge.
   task automatic cycle();
      int            g;
      logic          free;
      logic [NR-1:0] exp_ready;
      wr_t           w;
      #1;
      free      = (q.size() == 0) || rf_write_ready;
      g         = -1;
      exp_ready = '0;
      if (fill_next > 31 && free) g = pick(req_valid, rr);
      if (g >= 0) exp_ready[g] = 1'b1;

      check("req_ready", req_ready, exp_ready);
      check("wr_en", rf_write_enable, q.size() > 0);
      if (q.size() > 0) begin
         check("wr_reg", rf_write_register, q[0].r);
         check("wr_val", rf_write_value, q[0].d);
      end
      check("init_done", init_done, fill_next > 31);
`ifdef RF_WB_BYPASS_EN
      check("byp_valid", byp_valid, (q.size() > 0) && (fill_next > 31));
      if (q.size() > 0) begin
         check("byp_reg", byp_reg, q[0].r);
         check("byp_data", byp_data, q[0].d);
      end
`endif

      if (q.size() > 0 && rf_write_ready) void'(q.pop_front());
      if (fill_next <= 31) begin
         if (free) begin
            w.r = 5'(fill_next);
            w.d = 64'd0;
            q.push_back(w);
            fill_next++;
         end
      end else if (g >= 0) begin
         if (req_reg[g] != 5'd0) begin
            w.r = req_reg[g];
            w.d = req_data[g];
            q.push_back(w);
         end
         rr = (g + 1) % NR;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_reqs();
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
         req_reg[i]  = 5'($urandom_range(0, 31));
         req_data[i] = {$urandom, $urandom};
      end
   endtask

   initial begin
      reset          = 1'b0;
      req_valid      = '0;
      req_reg        = '0;
      req_data       = '0;
      rf_write_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // Zero-fill with requesters already clamouring for the port.
      repeat (36) begin
         rand_reqs();
         cycle();
      end

      // All three requesters continuously valid.
      req_valid   = 3'b111;
      req_reg[0]  = 5'd5;
      req_reg[1]  = 5'd6;
      req_reg[2]  = 5'd7;
      req_data[0] = 64'hA;
      req_data[1] = 64'hB;
      req_data[2] = 64'hC;
      repeat (9) cycle();

      // x0 request followed by a real one from the same requester.
      req_valid   = 3'b010;
      req_reg[1]  = 5'd0;
      req_data[1] = 64'hFF;
      cycle();
      req_reg[1]  = 5'd3;
      req_data[1] = 64'h11;
      cycle();
      req_valid = '0;
      repeat (2) cycle();

      // Back-pressure while reg 9 sits in the stage.
      req_valid   = 3'b001;
      req_reg[0]  = 5'd9;
      req_data[0] = 64'h99;
      cycle();
      req_valid      = 3'b111;
      rf_write_ready = 1'b0;
      repeat (4) cycle();
      rf_write_ready = 1'b1;
      repeat (3) cycle();

      // Random traffic with random back-pressure.
      repeat (300) begin
         rand_reqs();
         rf_write_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      // Reset while reg 12 = 0xDEAD is in flight.
      rf_write_ready = 1'b1;
      req_valid      = '0;
      repeat (2) cycle();
      req_valid   = 3'b100;
      req_reg[2]  = 5'd12;
      req_data[2] = 64'hDEAD;
      cycle();
      rf_write_ready = 1'b0;
      do_reset();
      rf_write_ready = 1'b1;
      repeat (40) begin
         rand_reqs();
         cycle();
      end

      // Forwarding case: reg 4 = 0x1234 accepted on an idle port.
      req_valid = '0;
      repeat (2) cycle();
      req_valid   = 3'b001;
      req_reg[0]  = 5'd4;
      req_data[0] = 64'h1234;
      cycle();
      req_valid = '0;
      repeat (2) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
